// File: rtl/alu_issue_queue.sv
// alu_issue_queue: reservation station feeding the integer ALU.
// Holds renamed micro-ops until both sources are ready. Sources wake up from the
// CDB, either while the op waits or in the cycle it is allocated. One ready entry
// is offered to the ALU each cycle.
// Optional build macro ALU_ISSUE_AGE_SELECT_EN: when defined, each entry keeps an
// age and select is oldest-first. When undefined, select takes the lowest ready index.
//
// Handshakes (both ports use valid/ready): a transfer happens on a rising edge
// where valid and ready are both high. Valid never depends on the same port's
// ready. alloc_ready depends only on the registered occupancy. issue_valid
// depends only on registered entry state.
module alu_issue_queue #(
  parameter int ENTRIES      = 4,
  parameter int TAG_WIDTH    = 6,
  parameter int XPR_LEN      = 32,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      alloc_valid,
  output logic                      alloc_ready,
  input  logic [ALU_OP_WIDTH-1:0]   alloc_op,
  input  logic                      alloc_src1_rdy,
  input  logic [XPR_LEN-1:0]        alloc_src1_val,
  input  logic [TAG_WIDTH-1:0]      alloc_src1_tag,
  input  logic                      alloc_src2_rdy,
  input  logic [XPR_LEN-1:0]        alloc_src2_val,
  input  logic [TAG_WIDTH-1:0]      alloc_src2_tag,
  input  logic [TAG_WIDTH-1:0]      alloc_dst_tag,
  input  logic                      cdb_valid,
  input  logic [TAG_WIDTH-1:0]      cdb_tag,
  input  logic [XPR_LEN-1:0]        cdb_data,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic [ALU_OP_WIDTH-1:0]   issue_op,
  output logic [XPR_LEN-1:0]        issue_in1,
  output logic [XPR_LEN-1:0]        issue_in2,
  output logic [TAG_WIDTH-1:0]      issue_dst_tag,
  output logic [$clog2(ENTRIES):0]  count
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = IW + 1;

  logic [ENTRIES-1:0]      valid_q, valid_d;
  logic [ENTRIES-1:0]      s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [ALU_OP_WIDTH-1:0] op_q [ENTRIES];
  logic [ALU_OP_WIDTH-1:0] op_d [ENTRIES];
  logic [XPR_LEN-1:0]      s1_val_q [ENTRIES];
  logic [XPR_LEN-1:0]      s1_val_d [ENTRIES];
  logic [XPR_LEN-1:0]      s2_val_q [ENTRIES];
  logic [XPR_LEN-1:0]      s2_val_d [ENTRIES];
  logic [TAG_WIDTH-1:0]    s1_tag_q [ENTRIES];
  logic [TAG_WIDTH-1:0]    s1_tag_d [ENTRIES];
  logic [TAG_WIDTH-1:0]    s2_tag_q [ENTRIES];
  logic [TAG_WIDTH-1:0]    s2_tag_d [ENTRIES];
  logic [TAG_WIDTH-1:0]    dst_q [ENTRIES];
  logic [TAG_WIDTH-1:0]    dst_d [ENTRIES];
  logic [CW-1:0]           count_q, count_d;

  logic [ENTRIES-1:0]      entry_rdy;
  logic [IW-1:0]           sel_idx, free_idx;
  logic                    alloc_fire, issue_fire;
  logic                    a1_byp, a2_byp;

`ifdef ALU_ISSUE_AGE_SELECT_EN
  logic [IW-1:0]           age_q [ENTRIES];
  logic [IW-1:0]           age_d [ENTRIES];
`endif

  assign entry_rdy   = valid_q & s1_rdy_q & s2_rdy_q;
  assign alloc_ready = (count_q != CW'(ENTRIES));
  assign issue_valid = |entry_rdy;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign issue_fire  = issue_valid & issue_ready;
  assign count       = count_q;
  assign a1_byp      = cdb_valid & (cdb_tag == alloc_src1_tag);
  assign a2_byp      = cdb_valid & (cdb_tag == alloc_src2_tag);

  // Issue outputs come from the selected entry and are forced to zero when nothing is ready.
  assign issue_op      = issue_valid ? op_q[sel_idx]     : '0;
  assign issue_in1     = issue_valid ? s1_val_q[sel_idx] : '0;
  assign issue_in2     = issue_valid ? s2_val_q[sel_idx] : '0;
  assign issue_dst_tag = issue_valid ? dst_q[sel_idx]    : '0;

  // Pick the lowest-index free slot for allocation.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

`ifdef ALU_ISSUE_AGE_SELECT_EN
  // Select the ready entry with the smallest age (oldest first).
  always_comb begin
    logic          found;
    logic [IW-1:0] best_age;
    found    = 1'b0;
    best_age = '0;
    sel_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entry_rdy[i] && (!found || (age_q[i] < best_age))) begin
        found    = 1'b1;
        best_age = age_q[i];
        sel_idx  = IW'(i);
      end
    end
  end
`else
  // Select the lowest-index ready entry.
  always_comb begin
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (entry_rdy[i]) sel_idx = IW'(i);
    end
  end
`endif

  // Next state: CDB wakeup, issue removal, allocation with same-cycle bypass, then flush.
  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    op_d     = op_q;
    s1_val_d = s1_val_q;
    s2_val_d = s2_val_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    dst_d    = dst_q;
    count_d  = count_q + CW'(alloc_fire) - CW'(issue_fire);
`ifdef ALU_ISSUE_AGE_SELECT_EN
    age_d    = age_q;
`endif

    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && cdb_valid) begin
        if (!s1_rdy_q[i] && (s1_tag_q[i] == cdb_tag)) begin
          s1_rdy_d[i] = 1'b1;
          s1_val_d[i] = cdb_data;
        end
        if (!s2_rdy_q[i] && (s2_tag_q[i] == cdb_tag)) begin
          s2_rdy_d[i] = 1'b1;
          s2_val_d[i] = cdb_data;
        end
      end
`ifdef ALU_ISSUE_AGE_SELECT_EN
      // Entries younger than the departing one move one step closer to the head.
      if (issue_fire && valid_q[i] && (age_q[i] > age_q[sel_idx])) begin
        age_d[i] = age_q[i] - IW'(1);
      end
`endif
    end

    if (issue_fire) valid_d[sel_idx] = 1'b0;

    if (alloc_fire) begin
      valid_d[free_idx]  = 1'b1;
      op_d[free_idx]     = alloc_op;
      dst_d[free_idx]    = alloc_dst_tag;
      s1_tag_d[free_idx] = alloc_src1_tag;
      s2_tag_d[free_idx] = alloc_src2_tag;
      s1_rdy_d[free_idx] = alloc_src1_rdy | a1_byp;
      s2_rdy_d[free_idx] = alloc_src2_rdy | a2_byp;
      s1_val_d[free_idx] = (!alloc_src1_rdy && a1_byp) ? cdb_data : alloc_src1_val;
      s2_val_d[free_idx] = (!alloc_src2_rdy && a2_byp) ? cdb_data : alloc_src2_val;
`ifdef ALU_ISSUE_AGE_SELECT_EN
      age_d[free_idx]    = IW'(count_q - CW'(issue_fire));
`endif
    end

    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end
  end

  // State registers; reset empties the queue immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]     <= '0;
        s1_val_q[i] <= '0;
        s2_val_q[i] <= '0;
        s1_tag_q[i] <= '0;
        s2_tag_q[i] <= '0;
        dst_q[i]    <= '0;
`ifdef ALU_ISSUE_AGE_SELECT_EN
        age_q[i]    <= '0;
`endif
      end
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      count_q  <= count_d;
      op_q     <= op_d;
      s1_val_q <= s1_val_d;
      s2_val_q <= s2_val_d;
      s1_tag_q <= s1_tag_d;
      s2_tag_q <= s2_tag_d;
      dst_q    <= dst_d;
`ifdef ALU_ISSUE_AGE_SELECT_EN
      age_q    <= age_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (ENTRIES=4). A slot-level behavioural model
// predicts every cycle's outputs. A scoreboard queue holds the expected issue
// stream {dst, in1, in2}. Literal expectations pin down the key scenarios.
module tb_alu_issue_queue;

  localparam int N = 4;
  typedef logic [69:0] cv_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [3:0]  alloc_op = '0;
  logic        alloc_src1_rdy = 1'b0;
  logic [31:0] alloc_src1_val = '0;
  logic [5:0]  alloc_src1_tag = '0;
  logic        alloc_src2_rdy = 1'b0;
  logic [31:0] alloc_src2_val = '0;
  logic [5:0]  alloc_src2_tag = '0;
  logic [5:0]  alloc_dst_tag = '0;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [3:0]  issue_op;
  logic [31:0] issue_in1;
  logic [31:0] issue_in2;
  logic [5:0]  issue_dst_tag;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  bit sb_on = 1'b1;
  logic [69:0] exp_q[$];

  alu_issue_queue #(
    .ENTRIES(N), .TAG_WIDTH(6), .XPR_LEN(32), .ALU_OP_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_src1_rdy(alloc_src1_rdy), .alloc_src1_val(alloc_src1_val), .alloc_src1_tag(alloc_src1_tag),
    .alloc_src2_rdy(alloc_src2_rdy), .alloc_src2_val(alloc_src2_val), .alloc_src2_tag(alloc_src2_tag),
    .alloc_dst_tag(alloc_dst_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_in1(issue_in1), .issue_in2(issue_in2), .issue_dst_tag(issue_dst_tag),
    .count(count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input cv_t act, input cv_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_v  [N];
  logic [3:0]  m_op [N];
  bit          m_r1 [N];
  bit          m_r2 [N];
  logic [31:0] m_v1 [N];
  logic [31:0] m_v2 [N];
  logic [5:0]  m_t1 [N];
  logic [5:0]  m_t2 [N];
  logic [5:0]  m_dst[N];
  int          m_cnt = 0;
`ifdef ALU_ISSUE_AGE_SELECT_EN
  int          m_seq[N];
  int          m_seq_ctr = 0;
`endif

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_cnt = 0;
  endtask

  // Returns the slot the ALU should see, or -1 when nothing is ready.
  function automatic int model_sel();
    int best = -1;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && m_r1[i] && m_r2[i]) begin
`ifdef ALU_ISSUE_AGE_SELECT_EN
        if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
        if (best < 0) best = i;
`endif
      end
    end
    return best;
  endfunction

  always @(negedge reset_n) model_clear();

  always @(posedge clk) begin
    int  s;
    int  fr;
    bit  fi;
    bit  fa;
    if (!reset_n) begin
      model_clear();
    end else begin
      s  = model_sel();
      fi = (s >= 0) && issue_ready;
      fa = alloc_valid && (m_cnt < N);
      fr = -1;
      for (int i = 0; i < N; i++) if (!m_v[i] && fr < 0) fr = i;
      if (flush) begin
        model_clear();
      end else begin
        if (cdb_valid) begin
          for (int i = 0; i < N; i++) begin
            if (m_v[i] && !m_r1[i] && m_t1[i] == cdb_tag) begin m_r1[i] = 1'b1; m_v1[i] = cdb_data; end
            if (m_v[i] && !m_r2[i] && m_t2[i] == cdb_tag) begin m_r2[i] = 1'b1; m_v2[i] = cdb_data; end
          end
        end
        if (fi) m_v[s] = 1'b0;
        if (fa) begin
          m_v[fr]   = 1'b1;
          m_op[fr]  = alloc_op;
          m_dst[fr] = alloc_dst_tag;
          m_t1[fr]  = alloc_src1_tag;
          m_t2[fr]  = alloc_src2_tag;
          m_r1[fr]  = alloc_src1_rdy || (cdb_valid && cdb_tag == alloc_src1_tag);
          m_r2[fr]  = alloc_src2_rdy || (cdb_valid && cdb_tag == alloc_src2_tag);
          m_v1[fr]  = alloc_src1_rdy ? alloc_src1_val : cdb_data;
          m_v2[fr]  = alloc_src2_rdy ? alloc_src2_val : cdb_data;
`ifdef ALU_ISSUE_AGE_SELECT_EN
          m_seq[fr] = m_seq_ctr;
          m_seq_ctr++;
`endif
        end
        m_cnt = m_cnt + int'(fa) - int'(fi);
      end
    end
  end

  // ---------------- compare process + scoreboard ----------------
  always @(negedge clk) begin
    int s;
    cv_t e;
    if (reset_n) begin
      s = model_sel();
      chk("alloc_ready", cv_t'(alloc_ready), cv_t'(m_cnt < N));
      chk("count", cv_t'(count), cv_t'(m_cnt));
      chk("issue_valid", cv_t'(issue_valid), cv_t'(s >= 0));
      if (s >= 0) begin
        chk("issue_op", cv_t'(issue_op), cv_t'(m_op[s]));
        chk("issue_in1", cv_t'(issue_in1), cv_t'(m_v1[s]));
        chk("issue_in2", cv_t'(issue_in2), cv_t'(m_v2[s]));
        chk("issue_dst_tag", cv_t'(issue_dst_tag), cv_t'(m_dst[s]));
      end else begin
        chk("idle_outputs_zero", cv_t'({issue_op, issue_in1, issue_in2, issue_dst_tag}), cv_t'(0));
      end
      if (sb_on && issue_valid && issue_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_issue actual_dst=%0d required=none", issue_dst_tag);
        end else begin
          e = exp_q.pop_front();
          chk("sb_issue", cv_t'({issue_dst_tag, issue_in1, issue_in2}), e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_step(input logic [3:0] op,
                            input logic r1, input logic [31:0] v1, input logic [5:0] t1,
                            input logic r2, input logic [31:0] v2, input logic [5:0] t2,
                            input logic [5:0] dst);
    alloc_valid    = 1'b1;
    alloc_op       = op;
    alloc_src1_rdy = r1;
    alloc_src1_val = v1;
    alloc_src1_tag = t1;
    alloc_src2_rdy = r2;
    alloc_src2_val = v2;
    alloc_src2_tag = t2;
    alloc_dst_tag  = dst;
    step();
    alloc_valid    = 1'b0;
  endtask

  task automatic cdb_step(input logic [5:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
    step();
    cdb_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [5:0] dst, input logic [31:0] in1, input logic [31:0] in2);
    exp_q.push_back({dst, in1, in2});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    model_clear();
    repeat (3) step();
    #2 reset_n = 1'b1;
    step();

    // Reset state
    chk("rst_count", cv_t'(count), cv_t'(0));
    chk("rst_issue_valid", cv_t'(issue_valid), cv_t'(0));
    chk("rst_alloc_ready", cv_t'(alloc_ready), cv_t'(1));
    chk("rst_issue_in1", cv_t'(issue_in1), cv_t'(0));

    // 1: both operands ready at alloc, issue visible the next cycle
    issue_ready = 1'b1;
    push_exp(6'd3, 32'd5, 32'd7);
    alloc_step(4'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 6'd3);
    chk("t1_issue_valid", cv_t'(issue_valid), cv_t'(1));
    chk("t1_in1", cv_t'(issue_in1), cv_t'(5));
    chk("t1_in2", cv_t'(issue_in2), cv_t'(7));
    chk("t1_dst", cv_t'(issue_dst_tag), cv_t'(3));
    chk("t1_count", cv_t'(count), cv_t'(1));
    step();
    chk("t1_count_after", cv_t'(count), cv_t'(0));
    chk("t1_valid_after", cv_t'(issue_valid), cv_t'(0));

    // 2: CDB wakeup two cycles after alloc
    push_exp(6'd10, 32'h1234, 32'd2);
    alloc_step(4'd1, 1'b0, 32'd0, 6'd9, 1'b1, 32'd2, 6'd0, 6'd10);
    chk("t2_wait0", cv_t'(issue_valid), cv_t'(0));
    step();
    chk("t2_wait1", cv_t'(issue_valid), cv_t'(0));
    cdb_step(6'd9, 32'h1234);
    chk("t2_woken", cv_t'(issue_valid), cv_t'(1));
    chk("t2_in1", cv_t'(issue_in1), cv_t'(32'h1234));
    step();
    chk("t2_count", cv_t'(count), cv_t'(0));

    // 3: CDB bypass into the allocating entry
    push_exp(6'd12, 32'd1, 32'hAA);
    cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'hAA;
    alloc_step(4'd2, 1'b1, 32'd1, 6'd0, 1'b0, 32'd0, 6'd4, 6'd12);
    cdb_valid = 1'b0;
    chk("t3_valid", cv_t'(issue_valid), cv_t'(1));
    chk("t3_in2", cv_t'(issue_in2), cv_t'(32'hAA));
    step();

    // 4: fill, reject while full, wake in reverse order, drain in slot order
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      alloc_step(4'(k), 1'b0, 32'd0, 6'(11 + k), 1'b1, 32'h200 + 32'(k), 6'd0, 6'(20 + k));
    chk("t4_count_full", cv_t'(count), cv_t'(4));
    chk("t4_alloc_ready", cv_t'(alloc_ready), cv_t'(0));
    alloc_step(4'd7, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 6'd30);
    chk("t4_fifth_ignored", cv_t'(count), cv_t'(4));
    for (int k = 3; k >= 0; k--) cdb_step(6'(11 + k), 32'h100 + 32'(11 + k));
    chk("t4_head_dst", cv_t'(issue_dst_tag), cv_t'(20));
    for (int k = 0; k < 4; k++) push_exp(6'(20 + k), 32'h100 + 32'(11 + k), 32'h200 + 32'(k));
    issue_ready = 1'b1;
    repeat (4) step();
    chk("t4_drained", cv_t'(count), cv_t'(0));

    // Slot reuse out of allocation order
    sb_on = 1'b0;
    issue_ready = 1'b0;
    alloc_step(4'd1, 1'b0, 32'd0, 6'd40, 1'b1, 32'd9, 6'd0, 6'd41);
    alloc_step(4'd2, 1'b0, 32'd0, 6'd42, 1'b1, 32'd9, 6'd0, 6'd43);
    alloc_step(4'd3, 1'b0, 32'd0, 6'd44, 1'b1, 32'd9, 6'd0, 6'd45);
    issue_ready = 1'b1;
    cdb_step(6'd42, 32'h42);
    step();
    issue_ready = 1'b0;
    alloc_step(4'd4, 1'b0, 32'd0, 6'd46, 1'b1, 32'd9, 6'd0, 6'd47);
    cdb_step(6'd44, 32'h44);
    cdb_step(6'd46, 32'h46);
`ifdef ALU_ISSUE_AGE_SELECT_EN
    chk("reuse_first", cv_t'(issue_dst_tag), cv_t'(45));
`else
    chk("reuse_first", cv_t'(issue_dst_tag), cv_t'(47));
`endif
    issue_ready = 1'b1;
    repeat (2) step();
    cdb_step(6'd40, 32'h40);
    repeat (2) step();
    chk("reuse_drained", cv_t'(count), cv_t'(0));
    sb_on = 1'b1;

    // 5: stall holds the selected entry, then flush discards everything
    issue_ready = 1'b0;
    alloc_step(4'd5, 1'b1, 32'h11, 6'd0, 1'b1, 32'h22, 6'd0, 6'd50);
    chk("t5_valid", cv_t'(issue_valid), cv_t'(1));
    chk("t5_dst", cv_t'(issue_dst_tag), cv_t'(50));
    repeat (3) step();
    chk("t5_hold_dst", cv_t'(issue_dst_tag), cv_t'(50));
    chk("t5_hold_in1", cv_t'(issue_in1), cv_t'(32'h11));
    chk("t5_hold_count", cv_t'(count), cv_t'(1));
    flush = 1'b1;
    issue_ready = 1'b1;
    alloc_step(4'd6, 1'b1, 32'h33, 6'd0, 1'b1, 32'h44, 6'd0, 6'd51);
    flush = 1'b0;
    issue_ready = 1'b0;
    chk("t5_flush_count", cv_t'(count), cv_t'(0));
    chk("t5_flush_valid", cv_t'(issue_valid), cv_t'(0));

    // 6: asynchronous reset with three entries occupied
    for (int k = 0; k < 3; k++)
      alloc_step(4'd1, 1'b0, 32'd0, 6'(60 + k), 1'b1, 32'd0, 6'd0, 6'(1 + k));
    chk("t6_count3", cv_t'(count), cv_t'(3));
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_count", cv_t'(count), cv_t'(0));
    chk("t6_async_valid", cv_t'(issue_valid), cv_t'(0));
    chk("t6_async_ready", cv_t'(alloc_ready), cv_t'(1));
    @(negedge clk);
    #2 reset_n = 1'b1;
    step();
    chk("t6_post_count", cv_t'(count), cv_t'(0));

    chk("sb_empty", cv_t'(exp_q.size()), cv_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
